// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   if_id_t       : IF/ID pipeline register payload
//   NOP_INSTR     : instruction word written into a bubble
package instr_fetch_stage_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               valid;
  } if_id_t;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, synchronous active-low reset (clears the whole register)
//   load       : capture d
//   bubble     : invalidate and zero the instruction; pc fields keep their value
//   d, q       : payload in / registered payload out
// With neither load nor bubble the register holds (stall).
module instr_fetch_stage_if_id_reg
  import instr_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: program counter, fetch FSM (FETCH/DONE), fetch counter and the
// IF/ID register feeding decode.
//   clk, rst_n             : clock, synchronous active-low reset
//   stall, flush           : hold / squash requests from decode
//   branch_taken/target    : redirect from execute (highest priority)
//   instruction            : word from combinational instruction memory at address
//   address                : current PC
//   if_id_*                : IF/ID register contents
//   done                   : fetch has run past LAST_ADDR
//   fetch_count            : valid instructions delivered into IF/ID
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] LAST_ADDR = PC_W'(16)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    address,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               done,
  output logic [31:0]        fetch_count
);

  fetch_state_t      state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic              load_c;
  logic              bubble_c;
  if_id_t            if_id_d;
  if_id_t            if_id_q;

  assign pc_inc  = pc + PC_W'(1);
  assign address = pc;
  assign done    = (state == DONE);

  // IF/ID control: branch/flush squash; stall holds; DONE feeds bubbles.
  always_comb begin
    bubble_c = 1'b0;
    load_c   = 1'b0;
    if (branch_taken || flush) begin
      bubble_c = 1'b1;
    end else if (!stall) begin
      if (state == FETCH) load_c   = 1'b1;
      else                bubble_c = 1'b1;
    end
  end

  assign if_id_d = '{instr: instruction, pc: pc, pc_plus1: pc_inc, valid: 1'b1};

  // PC, FSM and fetch counter. Any PC load past LAST_ADDR lands in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= FETCH;
      fetch_count <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= (branch_target > LAST_ADDR) ? DONE : FETCH;
          end else if (flush) begin
            pc    <= pc_inc;
            state <= (pc_inc > LAST_ADDR) ? DONE : FETCH;
          end else if (!stall) begin
            pc          <= pc_inc;
            fetch_count <= fetch_count + 32'd1;
            state       <= (pc_inc > LAST_ADDR) ? DONE : FETCH;
          end
        end
        DONE: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= (branch_target > LAST_ADDR) ? DONE : FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  instr_fetch_stage_if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_c),
    .bubble (bubble_c),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_instruction = if_id_q.instr;
  assign if_id_pc          = if_id_q.pc;
  assign if_id_pc_plus1    = if_id_q.pc_plus1;
  assign if_id_valid       = if_id_q.valid;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Fetch stage of the pipelined core. It holds the program counter and drives ADDRESS into the combinational instruction memory. It captures the returned INSTRUCTION into the IF/ID pipeline register that feeds decode. It also handles stall, flush, branch redirect and end-of-program detection.

Parameters:
RESET_PC, 0, PC value loaded on reset; word-addressed (one instruction per address).
LAST_ADDR, 16, highest valid program address; fetching beyond it enters DONE.
PC_W, 32, width of PC, ADDRESS and all PC-carrying outputs.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset
STALL  input  1  hazard stall from decode; hold PC and IF/ID
FLUSH  input  1  squash the IF/ID contents and the instruction fetched this cycle
BRANCH_TAKEN  input  1  redirect request from execute
BRANCH_TARGET  input  PC_W  redirect address
INSTRUCTION  input  32  word returned by instruction memory for ADDRESS (same cycle)
ADDRESS  output  PC_W  current PC, driven combinationally from the PC register
IF_ID_INSTRUCTION  output  32  registered instruction to decode
IF_ID_PC  output  PC_W  address of IF_ID_INSTRUCTION
IF_ID_PC_PLUS1  output  PC_W  IF_ID_PC + 1
IF_ID_VALID  output  1  IF/ID holds a real instruction (0 = bubble)
DONE  output  1  high while in DONE state
FETCH_COUNT  output  32  number of instructions written into IF/ID as valid

Behaviour:
- Reset is synchronous and active-low. On a CLK edge with RST_N=0: PC<=RESET_PC, state<=FETCH, IF_ID_INSTRUCTION<=0, IF_ID_PC<=0, IF_ID_PC_PLUS1<=0, IF_ID_VALID<=0, FETCH_COUNT<=0, DONE=0.
- Reset mid-operation discards everything, including a pending redirect.
- ADDRESS=PC at all times. Memory is combinational, so fetch latency is 1 cycle: the word at address A appears on IF_ID_INSTRUCTION the edge after PC=A.
- States: FETCH, DONE.
- Per-edge priority in FETCH, highest first:
  1. BRANCH_TAKEN: PC<=BRANCH_TARGET; IF/ID<=bubble (VALID=0, INSTRUCTION=0). Applies even when STALL=1.
  2. FLUSH: IF/ID<=bubble; PC<=PC+1.
  3. STALL: PC and all IF/ID outputs hold their values; FETCH_COUNT holds.
  4. Normal: IF/ID<={INSTRUCTION, PC, PC+1, VALID=1}; PC<=PC+1; FETCH_COUNT+=1.
- FETCH->DONE transition: on a normal advance where PC==LAST_ADDR, the instruction is captured and state<=DONE. PC then stops at LAST_ADDR+1.
- In DONE:
  - DONE=1, PC holds, and each non-stalled edge writes a bubble into IF/ID.
  - STALL holds IF/ID as in FETCH.
  - BRANCH_TAKEN returns to FETCH with PC<=BRANCH_TARGET and writes a bubble.
  - FLUSH in DONE writes a bubble only.
- BRANCH_TARGET > LAST_ADDR: PC loads the target and state goes to DONE on the same edge.
- PC arithmetic is modulo 2^PC_W; PC+1 wraps 2^PC_W-1 to 0. FETCH_COUNT wraps modulo 2^32.
- Simultaneous FLUSH and STALL: FLUSH wins. Simultaneous BRANCH_TAKEN and FLUSH: single bubble, branch target loaded.

Decomposition:
- myPackage gains:
  - fetch_state_t enum {FETCH, DONE}.
  - if_id_t packed struct {instr[31:0], pc, pc_plus1, valid}.
  - NOP_INSTR=32'b0 constant.
- One sub-module is natural: if_id_reg, which holds the if_id_t register with load/bubble/hold controls and the synchronous active-low reset.
- PC, FSM and FETCH_COUNT stay in the top module.

Test Plan:
- Reset, then 4 free-running edges with memory returning 0xA0+address -> ADDRESS 0,1,2,3,4; IF_ID_PC 0..3 with instr 0xA0..0xA3, VALID=1; FETCH_COUNT=4.
- STALL=1 for 2 cycles at PC=3 -> ADDRESS stays 3; IF_ID_PC stays 2, VALID=1; FETCH_COUNT unchanged; on release IF_ID_PC=3 next edge.
- BRANCH_TAKEN=1, BRANCH_TARGET=9, with STALL=1 at PC=5 -> next edge PC=9, VALID=0; following edge IF_ID_PC=9, IF_ID_PC_PLUS1=10, VALID=1.
- FLUSH=1 at PC=6 -> VALID=0, INSTRUCTION 0, PC=7; the word at 6 never reaches decode and FETCH_COUNT is not incremented.
- Run to LAST_ADDR=16 -> IF_ID_PC=16 valid, DONE=1, ADDRESS held at 17, bubbles thereafter; BRANCH_TAKEN to 0 -> DONE=0, fetch resumes at 0.
- Assert RST_N=0 for one edge while in DONE with BRANCH_TAKEN=1 -> PC=0, state FETCH, VALID=0, FETCH_COUNT=0; branch ignored.
